// File: rtl/tank_life_if.sv
// -----------------------------------------------------------------------------
// tank_life_if
// Bundle between the game logic / tank datapath and tank_life_ctrl.
//
// Signals:
//   startOfFrame : one-cycle pulse at each frame start        (game -> ctrl)
//   startGame    : start key level, rising edge acts          (game -> ctrl)
//   tankHit      : missile hit on this tank, level or pulse   (game -> ctrl)
//   runEn        : movement enable for the tank mover         (ctrl -> tank)
//   resetPos     : position reload for the tank mover         (ctrl -> tank)
//   tankVisible  : sprite draw enable                         (ctrl -> tank)
//   livesLeft    : remaining lives, 3 bits                    (ctrl -> HUD)
//   gameOver     : high while the game is over                (ctrl -> HUD)
//   state        : current sequencer state, 3 bits            (ctrl -> HUD)
//
// Modports: master = game logic side, slave = tank_life_ctrl.
// -----------------------------------------------------------------------------
interface tank_life_if;
    logic       startOfFrame;
    logic       startGame;
    logic       tankHit;
    logic       runEn;
    logic       resetPos;
    logic       tankVisible;
    logic [2:0] livesLeft;
    logic       gameOver;
    logic [2:0] state;

    modport master (
        output startOfFrame, startGame, tankHit,
        input  runEn, resetPos, tankVisible, livesLeft, gameOver, state
    );

    modport slave (
        input  startOfFrame, startGame, tankHit,
        output runEn, resetPos, tankVisible, livesLeft, gameOver, state
    );
endinterface

// File: rtl/tank_life_ctrl.sv
// -----------------------------------------------------------------------------
// tank_life_ctrl
// Round and lives sequencer for one player tank. Walks the tank through
// IDLE -> SPAWN -> COUNTDOWN -> RUN -> HIT -> (SPAWN | GAME_OVER), counting
// all delays in frames, blinking the sprite while spawning or hit, and
// tracking remaining lives.
//
// Parameters:
//   LIVES        : lives loaded at game start (1..7)
//   SPAWN_FRAMES : countdown frames before the tank may move (1..255)
//   HIT_FRAMES   : frames frozen after a hit (1..255)
//   BLINK_PERIOD : frames per visible/invisible half-cycle (1..255)
//
// Ports:
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : tank_life_if.slave (frame pulse, start key, hit in;
//            runEn, resetPos, tankVisible, livesLeft, gameOver, state out)
//
// All outputs are registered; each one is computed from the next state so it
// changes on the same edge as the transition.
// -----------------------------------------------------------------------------
module tank_life_ctrl #(
    parameter int LIVES        = 3,
    parameter int SPAWN_FRAMES = 60,
    parameter int HIT_FRAMES   = 45,
    parameter int BLINK_PERIOD = 8
) (
    input  logic       clk,
    input  logic       resetN,
    tank_life_if.slave bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SPAWN     = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_HIT       = 3'd4;
    localparam logic [2:0] ST_GAMEOVER  = 3'd5;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_FRAMES - 1);
    localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

    logic [2:0] r_state;
    logic [2:0] w_nextState;

    logic [7:0] r_frameCnt;
    logic [7:0] r_blinkCnt;
    logic [2:0] r_livesLeft;
    logic       r_startPrev;

    logic       r_runEn;
    logic       r_resetPos;
    logic       r_tankVisible;
    logic       r_gameOver;

    logic       w_startEdge;
    logic       w_counting;
    logic       w_frameLast;
    logic       w_frameDone;
    logic       w_blinkWrap;
    logic       w_hitTaken;

    logic [7:0] w_frameCntNext;
    logic [7:0] w_blinkCntNext;
    logic [2:0] w_livesNext;

    logic       w_runEnNext;
    logic       w_resetPosNext;
    logic       w_visNext;
    logic       w_gameOverNext;

    // startPrev powers up high so a key already held at reset is not an edge
    assign w_startEdge = bus.startGame & ~r_startPrev;

    // COUNTDOWN and HIT share the same frame/blink counting machinery
    assign w_counting  = (r_state == ST_COUNTDOWN) || (r_state == ST_HIT);
    assign w_frameLast = (r_state == ST_HIT) ? (r_frameCnt == HIT_LAST)
                                             : (r_frameCnt == SPAWN_LAST);
    assign w_frameDone = w_counting & bus.startOfFrame & w_frameLast;
    assign w_blinkWrap = w_counting & bus.startOfFrame & (r_blinkCnt == BLINK_LAST);

    // a hit only counts in RUN; hits during HIT must not decrement again
    assign w_hitTaken  = (r_state == ST_RUN) & bus.tankHit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_startEdge) w_nextState = ST_SPAWN;
            end
            ST_SPAWN: begin
                w_nextState = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (w_frameDone) w_nextState = ST_RUN;
            end
            ST_RUN: begin
                if (bus.tankHit) w_nextState = ST_HIT;
            end
            ST_HIT: begin
                if (w_frameDone) begin
                    w_nextState = (r_livesLeft == 3'd0) ? ST_GAMEOVER : ST_SPAWN;
                end
            end
            ST_GAMEOVER: begin
                if (w_startEdge) w_nextState = ST_SPAWN;
            end
            default: begin
                // codes 6 and 7 recover to IDLE
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (next-cycle output values, registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        w_runEnNext    = 1'b0;
        w_resetPosNext = 1'b0;
        w_visNext      = 1'b0;
        w_gameOverNext = 1'b0;
        case (w_nextState)
            ST_IDLE: begin
                w_resetPosNext = 1'b1;
            end
            ST_SPAWN: begin
                w_resetPosNext = 1'b1;
                w_visNext      = 1'b1;
            end
            ST_COUNTDOWN, ST_HIT: begin
                // visible on entry, then toggled each time the blink counter wraps
                if (w_nextState != r_state) begin
                    w_visNext = 1'b1;
                end else begin
                    w_visNext = r_tankVisible ^ w_blinkWrap;
                end
            end
            ST_RUN: begin
                w_runEnNext = 1'b1;
                w_visNext   = 1'b1;
            end
            ST_GAMEOVER: begin
                w_gameOverNext = 1'b1;
            end
            default: begin
                w_resetPosNext = 1'b1;
            end
        endcase
    end

    // frame/blink counters: cleared on SPAWN and on a hit, advanced per frame
    // while counting; they wrap to 0 rather than running past their limit
    always_comb begin
        w_frameCntNext = r_frameCnt;
        w_blinkCntNext = r_blinkCnt;
        if ((r_state == ST_SPAWN) || w_hitTaken) begin
            w_frameCntNext = 8'd0;
            w_blinkCntNext = 8'd0;
        end else if (w_counting && bus.startOfFrame) begin
            w_frameCntNext = w_frameLast ? 8'd0 : (r_frameCnt + 8'd1);
            w_blinkCntNext = w_blinkWrap ? 8'd0 : (r_blinkCnt + 8'd1);
        end
    end

    // lives: reload on a start edge from IDLE/GAME_OVER, saturating decrement on a hit
    always_comb begin
        w_livesNext = r_livesLeft;
        if (((r_state == ST_IDLE) || (r_state == ST_GAMEOVER)) && w_startEdge) begin
            w_livesNext = LIVES_INIT;
        end else if (w_hitTaken && (r_livesLeft != 3'd0)) begin
            w_livesNext = r_livesLeft - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frameCnt    <= 8'd0;
            r_blinkCnt    <= 8'd0;
            r_livesLeft   <= LIVES_INIT;
            r_startPrev   <= 1'b1;
            r_runEn       <= 1'b0;
            r_resetPos    <= 1'b1;
            r_tankVisible <= 1'b0;
            r_gameOver    <= 1'b0;
        end else begin
            r_frameCnt    <= w_frameCntNext;
            r_blinkCnt    <= w_blinkCntNext;
            r_livesLeft   <= w_livesNext;
            r_startPrev   <= bus.startGame;
            r_runEn       <= w_runEnNext;
            r_resetPos    <= w_resetPosNext;
            r_tankVisible <= w_visNext;
            r_gameOver    <= w_gameOverNext;
        end
    end

    assign bus.runEn       = r_runEn;
    assign bus.resetPos    = r_resetPos;
    assign bus.tankVisible = r_tankVisible;
    assign bus.livesLeft   = r_livesLeft;
    assign bus.gameOver    = r_gameOver;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_tank_life_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tank_life_ctrl
// Directed table of game steps with expected outputs, a hand-written
// asynchronous reset sequence, then randomized play against a frame-counting
// reference model.
// -----------------------------------------------------------------------------
module tb_tank_life_ctrl;
    localparam int LIVES = 2;
    localparam int SF    = 4;
    localparam int HF    = 3;
    localparam int BP    = 2;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    tank_life_if bus();

    tank_life_ctrl #(
        .LIVES       (LIVES),
        .SPAWN_FRAMES(SF),
        .HIT_FRAMES  (HF),
        .BLINK_PERIOD(BP)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: state code, frames seen since entering the phase, lives
    int m_state;
    int m_seen;
    int m_lives;
    bit m_prev;

    logic [9:0] w_dut;
    assign w_dut = {bus.state, bus.runEn, bus.resetPos, bus.tankVisible,
                    bus.livesLeft, bus.gameOver};

    typedef enum int {K_IDLE, K_START, K_HIT, K_HITSOF, K_FRAMES} kind_t;
    typedef struct {
        kind_t kind;
        int    arg;
        int    st;
        int    run;
        int    rp;
        int    vis;
        int    lives;
        int    go;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [9:0] pack_exp(int st, int run, int rp, int vis, int lives, int go);
        return {3'(st), 1'(run), 1'(rp), 1'(vis), 3'(lives), 1'(go)};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d run=%0b rp=%0b vis=%0b lives=%0d go=%0b, want st=%0d run=%0b rp=%0b vis=%0b lives=%0d go=%0b",
                     name, act[9:7], act[6], act[5], act[4], act[3:1], act[0],
                     exp[9:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_seen  = 0;
        m_lives = LIVES;
        m_prev  = 1'b1;
    endtask

    task automatic model_step(input bit sof, input bit start, input bit hit);
        bit sedge;
        sedge  = start && !m_prev;
        m_prev = start;
        case (m_state)
            0: if (sedge) begin m_lives = LIVES; m_state = 1; end
            1: begin m_state = 2; m_seen = 0; end
            2: if (sof) begin
                   m_seen++;
                   if (m_seen == SF) m_state = 3;
               end
            3: if (hit) begin
                   m_state = 4;
                   m_seen  = 0;
                   if (m_lives > 0) m_lives--;
               end
            4: if (sof) begin
                   m_seen++;
                   if (m_seen == HF) m_state = (m_lives == 0) ? 5 : 1;
               end
            5: if (sedge) begin m_lives = LIVES; m_state = 1; end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [9:0] model_out();
        int vis;
        case (m_state)
            1, 3:    vis = 1;
            2, 4:    vis = (((m_seen / BP) % 2) == 0) ? 1 : 0;
            default: vis = 0;
        endcase
        return pack_exp(m_state, (m_state == 3) ? 1 : 0, (m_state <= 1) ? 1 : 0,
                        vis, m_lives, (m_state == 5) ? 1 : 0);
    endfunction

    task automatic do_cycle(input bit sof, input bit start, input bit hit);
        bus.startOfFrame = sof;
        bus.startGame    = start;
        bus.tankHit      = hit;
        if (resetN) model_step(sof, start, hit);
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("model@%0d", cyc), w_dut, model_out());
    endtask

    task automatic add(kind_t k, int a, int st, int run, int rp, int vis, int lives, int go);
        vec_t v;
        v = '{k, a, st, run, rp, vis, lives, go};
        vecs.push_back(v);
    endtask

    initial begin
        bit st;

        //   kind      arg st run rp vis lives go
        add(K_IDLE,    3, 0, 0, 1, 0, 2, 0);
        add(K_START,   0, 1, 0, 1, 1, 2, 0);  // one SPAWN cycle
        add(K_IDLE,    1, 2, 0, 0, 1, 2, 0);  // COUNTDOWN, visible on entry
        add(K_FRAMES,  1, 2, 0, 0, 1, 2, 0);
        add(K_FRAMES,  1, 2, 0, 0, 0, 2, 0);  // blink toggles after 2 frames
        add(K_FRAMES,  1, 2, 0, 0, 0, 2, 0);
        add(K_FRAMES,  1, 3, 1, 0, 1, 2, 0);  // 4th frame -> RUN
        add(K_IDLE,    5, 3, 1, 0, 1, 2, 0);
        add(K_HITSOF,  0, 4, 0, 0, 1, 1, 0);  // hit beats coincident frame
        add(K_HIT,     0, 4, 0, 0, 1, 1, 0);  // no double decrement
        add(K_FRAMES,  1, 4, 0, 0, 1, 1, 0);
        add(K_FRAMES,  1, 4, 0, 0, 0, 1, 0);
        add(K_FRAMES,  1, 1, 0, 1, 1, 1, 0);  // 3rd frame -> SPAWN
        add(K_IDLE,    1, 2, 0, 0, 1, 1, 0);
        add(K_START,   0, 2, 0, 0, 1, 1, 0);  // start ignored in COUNTDOWN
        add(K_FRAMES,  4, 3, 1, 0, 1, 1, 0);
        add(K_START,   0, 3, 1, 0, 1, 1, 0);  // start ignored in RUN
        add(K_HIT,     0, 4, 0, 0, 1, 0, 0);
        add(K_FRAMES,  3, 5, 0, 0, 0, 0, 1);  // last life gone
        add(K_IDLE,    4, 5, 0, 0, 0, 0, 1);
        add(K_START,   0, 1, 0, 1, 1, 2, 0);  // restart reloads lives
        add(K_IDLE,    1, 2, 0, 0, 1, 2, 0);
        add(K_FRAMES,  4, 3, 1, 0, 1, 2, 0);
        add(K_HIT,     0, 4, 0, 0, 1, 1, 0);
        add(K_FRAMES,  1, 4, 0, 0, 1, 1, 0);

        // reset with the start key already held
        bus.startOfFrame = 1'b0;
        bus.startGame    = 1'b1;
        bus.tankHit      = 1'b0;
        resetN           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", w_dut, pack_exp(0, 0, 1, 0, 2, 0));
        resetN = 1'b1;
        repeat (5) do_cycle(1'b0, 1'b1, 1'b0);
        check("held_start_no_edge", w_dut, pack_exp(0, 0, 1, 0, 2, 0));

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_IDLE:   repeat (vecs[i].arg) do_cycle(1'b0, 1'b0, 1'b0);
                K_START:  do_cycle(1'b0, 1'b1, 1'b0);
                K_HIT:    do_cycle(1'b0, 1'b0, 1'b1);
                K_HITSOF: do_cycle(1'b1, 1'b0, 1'b1);
                K_FRAMES: repeat (vecs[i].arg) begin
                              repeat (9) do_cycle(1'b0, 1'b0, 1'b0);
                              do_cycle(1'b1, 1'b0, 1'b0);
                          end
                default:  do_cycle(1'b0, 1'b0, 1'b0);
            endcase
            check($sformatf("vec%0d", i), w_dut,
                  pack_exp(vecs[i].st, vecs[i].run, vecs[i].rp, vecs[i].vis,
                           vecs[i].lives, vecs[i].go));
        end

        // asynchronous reset in the middle of a HIT cycle
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check("async_reset", w_dut, pack_exp(0, 0, 1, 0, 2, 0));
        @(posedge clk);
        #1;
        check("reset_hold", w_dut, pack_exp(0, 0, 1, 0, 2, 0));
        resetN = 1'b1;

        // randomized play, frame pulse every 10 clocks
        st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) st = ~st;
            do_cycle((cyc % 10) == 0, st, $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
